conv_layer_param: RTL and testbench
===================================

Name: conv_layer_param

Overview:
- Generic, parametrised convolution-layer engine. Successor to the fixed-size per-layer conv blocks in the LeNet datapath.
- Computes every output pixel of every filter. Inputs are a feature map in the shared result BRAM, plus weights and bias in the shared bias/weights BRAM. Results go back to the result BRAM.
- Adds features the fixed-size blocks lack:
  - configurable kernel, input size, stride and channel counts
  - a sequential MAC with a saturating accumulator
  - configurable BRAM read latency
  - optional ReLU
  - start/busy/done handshake
- Sits between the pooling stage and the next layer; the top-level controller sequences it.

Parameters:
- DATA_SIZE, 16, signed fixed-point word width
- FRAC_BITS, 8, fractional bits of the data/weight format
- IN_CH, 16, input channels
- OUT_CH, 120, filters
- IN_SIZE, 5, input feature-map side length
- K_SIZE, 5, kernel side length
- STRIDE, 1, convolution stride
- RD_LAT, 2, BRAM read latency in cycles (douta valid RD_LAT cycles after ena+addr)
- RELU_EN, 1, apply ReLU before store
- IN_BASE, 7480, feature-map base address in result BRAM
- W_BASE, 2572, weight base address in bias/weights BRAM
- B_BASE, 50572, bias base address in bias/weights BRAM
- OUT_BASE, 7880, output base address in result BRAM

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; starts a layer pass when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last result is written
- bias_weights_bram_ena  out  1  read enable
- bias_weights_bram_addra  out  16  read address
- bias_weights_bram_douta  in  DATA_SIZE  read data
- result_bram_ena  out  1  enable
- result_bram_wea  out  1  write enable
- result_bram_addra  out  13  address
- result_bram_dina  out  DATA_SIZE  write data
- result_bram_douta  in  DATA_SIZE  read data

Behaviour:
- Reset (async): every output is 0, state IDLE, all counters and the accumulator cleared. Reset mid-pass aborts the pass; no further BRAM access and no done.
- OUT_SIZE = (IN_SIZE-K_SIZE)/STRIDE+1.
- Loop order: filter f, out row r, out col c, then channel ch, ky, kx (innermost).
- States:
  - IDLE: wait for start. A start pulse while busy is ignored.
  - LOAD_BIAS:
    - read B_BASE+f and wait RD_LAT cycles.
    - acc = sign-extended bias << FRAC_BITS.
  - FETCH:
    - Both BRAMs are enabled in the same cycle.
    - Weight address: W_BASE+((f*IN_CH+ch)*K_SIZE+ky)*K_SIZE+kx.
    - Data address: IN_BASE+ch*IN_SIZE*IN_SIZE+(r*STRIDE+ky)*IN_SIZE+c*STRIDE+kx.
  - WAIT: RD_LAT cycles; enables drop after the first.
  - MAC:
    - acc += weight*data as a full 2*DATA_SIZE-bit signed product.
    - Accumulator width is 2*DATA_SIZE+8, so no overflow is possible for these parameters.
    - Advance kx/ky/ch; go to FETCH, or to STORE after the last element.
  - STORE:
    - y = acc >>> FRAC_BITS (arithmetic), saturated to the signed DATA_SIZE range. ReLU (y<0 -> 0) is applied if RELU_EN.
    - One write cycle: ena=wea=1, address OUT_BASE+f*OUT_SIZE*OUT_SIZE+r*OUT_SIZE+c.
    - Next cycle ena=wea=0. Then advance c/r/f and go to LOAD_BIAS, or to FINISH after the last.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- The bias is reloaded per output pixel.
- Latency per output pixel: (RD_LAT+2) + IN_CH*K_SIZE*K_SIZE*(RD_LAT+2) + 2 cycles.
- Edge cases:
  - Write and read never overlap.
  - The feature-map region must not overlap the output region. This is the integrator's duty; no check is made.
  - K_SIZE==IN_SIZE gives a 1x1 output, which is equivalent to fully-connected behaviour.
- Counter widths are sized with $clog2 of their bounds; no integer-typed registers.

Decomposition:
- Shared package lenet_pkg holds:
  - the DATA_SIZE and FRAC_BITS defaults
  - BRAM address widths (16, 13)
  - the memory-map base-address constants
  - a saturate-to-DATA_SIZE function
- One sub-module, conv_mac:
  - inputs: clear-with-bias load, enable, signed operands
  - function: registered saturating accumulator and the shift/saturate/ReLU output stage

Test Plan:
- IN_CH=1, OUT_CH=1, IN_SIZE=3, K_SIZE=3: all data 1.0 (0x0100), weights 1.0, bias 0 -> single write of 0x0900 at OUT_BASE, then done pulses once.
- IN_SIZE=4, K_SIZE=3, STRIDE=1, data = index*1.0 (0..15), weights 1.0 -> 4 writes: 0x2D00, 0x3600, 0x5100, 0x5A00 at OUT_BASE+0..3.
- Weights -1.0, data 1.0, bias 0, RELU_EN=1 -> 0x0000; RELU_EN=0 -> 0xF700 (-9.0).
- Data 0x7FFF, weights 0x7FFF, 3x3 -> saturated 0x7FFF; negated weights -> 0x8000 with RELU_EN=0.
- Assert rst mid-MAC -> outputs 0 asynchronously, no write, no done. A new start then completes a full pass correctly.
- RD_LAT=1 and 3 with the scenario-2 data -> identical results, cycle count matches the latency formula; a start pulse while busy is ignored.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants: word format, BRAM address widths,
// memory map, FSM states and helper functions.
package lenet_pkg;

  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int BW_AW         = 16;
  localparam int RES_AW        = 13;

  localparam int MM_IN_BASE  = 7480;
  localparam int MM_W_BASE   = 2572;
  localparam int MM_B_BASE   = 50572;
  localparam int MM_OUT_BASE = 7880;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_FETCH,
    S_WAIT,
    S_MAC,
    S_WR,
    S_NXT,
    S_FIN
  } conv_state_t;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Sequential MAC: bias-loaded wide accumulator with
// shift / saturate / optional ReLU output stage.
module conv_mac
  import lenet_pkg::*;
#(
  parameter int DW   = DEF_DATA_SIZE,
  parameter int FB   = DEF_FRAC_BITS,
  parameter int RELU = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [DW-1:0] i_bias,
  input  logic [DW-1:0] i_w,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_y
);

  localparam int AW = 2 * DW + 8;

  logic signed [AW-1:0]   r_acc;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_bias;
  logic signed [AW-1:0]   w_sh;
  logic        [DW-1:0]   w_y;

  assign w_prod = $signed(i_w) * $signed(i_d);
  assign w_bias = AW'($signed(i_bias)) <<< FB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_bias;
    end else if (i_en) begin
      r_acc <= r_acc + AW'(w_prod);
    end
  end

  assign w_sh = r_acc >>> FB;
  assign w_y  = DW'(sat(64'(w_sh), DW));
  assign o_y  = (RELU != 0 && w_y[DW-1]) ? '0 : w_y;

endmodule

// File: rtl/conv_layer_param.sv
// Parametrised convolution layer: walks filters/pixels/taps, streams
// operands from the two BRAMs through conv_mac and writes results back.
module conv_layer_param
  import lenet_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int IN_CH     = 16,
  parameter int OUT_CH    = 120,
  parameter int IN_SIZE   = 5,
  parameter int K_SIZE    = 5,
  parameter int STRIDE    = 1,
  parameter int RD_LAT    = 2,
  parameter int RELU_EN   = 1,
  parameter int IN_BASE   = MM_IN_BASE,
  parameter int W_BASE    = MM_W_BASE,
  parameter int B_BASE    = MM_B_BASE,
  parameter int OUT_BASE  = MM_OUT_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 bias_weights_bram_ena,
  output logic [BW_AW-1:0]     bias_weights_bram_addra,
  input  logic [DATA_SIZE-1:0] bias_weights_bram_douta,
  output logic                 result_bram_ena,
  output logic                 result_bram_wea,
  output logic [RES_AW-1:0]    result_bram_addra,
  output logic [DATA_SIZE-1:0] result_bram_dina,
  input  logic [DATA_SIZE-1:0] result_bram_douta
);

  localparam int OUT_SIZE = (IN_SIZE - K_SIZE) / STRIDE + 1;
  localparam int FW = cw(OUT_CH);
  localparam int OW = cw(OUT_SIZE);
  localparam int CW = cw(IN_CH);
  localparam int KW = cw(K_SIZE);
  localparam int WW = cw(RD_LAT + 2);

  conv_state_t r_state, w_nxt;

  logic [FW-1:0] r_f;
  logic [OW-1:0] r_r, r_c;
  logic [CW-1:0] r_ch;
  logic [KW-1:0] r_ky, r_kx;
  logic [WW-1:0] r_wait;

  logic w_load, w_en, w_last_el, w_last_px;
  logic [DATA_SIZE-1:0] w_y;
  logic [BW_AW-1:0]     w_baddr, w_waddr;
  logic [RES_AW-1:0]    w_daddr, w_oaddr;

  assign w_baddr = BW_AW'(B_BASE) + BW_AW'(r_f);
  assign w_waddr = BW_AW'(W_BASE)
    + ((BW_AW'(r_f) * BW_AW'(IN_CH) + BW_AW'(r_ch))
    * BW_AW'(K_SIZE) + BW_AW'(r_ky)) * BW_AW'(K_SIZE)
    + BW_AW'(r_kx);
  assign w_daddr = RES_AW'(IN_BASE)
    + RES_AW'(r_ch) * RES_AW'(IN_SIZE * IN_SIZE)
    + (RES_AW'(r_r) * RES_AW'(STRIDE) + RES_AW'(r_ky))
    * RES_AW'(IN_SIZE)
    + RES_AW'(r_c) * RES_AW'(STRIDE) + RES_AW'(r_kx);
  assign w_oaddr = RES_AW'(OUT_BASE)
    + RES_AW'(r_f) * RES_AW'(OUT_SIZE * OUT_SIZE)
    + RES_AW'(r_r) * RES_AW'(OUT_SIZE) + RES_AW'(r_c);

  assign w_last_el = r_kx == KW'(K_SIZE - 1)
    && r_ky == KW'(K_SIZE - 1) && r_ch == CW'(IN_CH - 1);
  assign w_last_px = r_c == OW'(OUT_SIZE - 1)
    && r_r == OW'(OUT_SIZE - 1) && r_f == FW'(OUT_CH - 1);

  conv_mac #(
    .DW  (DATA_SIZE),
    .FB  (FRAC_BITS),
    .RELU(RELU_EN)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_en  (w_en),
    .i_bias(bias_weights_bram_douta),
    .i_w   (bias_weights_bram_douta),
    .i_d   (result_bram_douta),
    .o_y   (w_y)
  );

  always_comb begin
    w_nxt                   = r_state;
    busy                    = 1'b0;
    done                    = 1'b0;
    bias_weights_bram_ena   = 1'b0;
    bias_weights_bram_addra = '0;
    result_bram_ena         = 1'b0;
    result_bram_wea         = 1'b0;
    result_bram_addra       = '0;
    result_bram_dina        = '0;
    w_load                  = 1'b0;
    w_en                    = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_nxt = S_BIAS;
      S_BIAS: begin
        busy = 1'b1;
        bias_weights_bram_addra = w_baddr;
        bias_weights_bram_ena   = (r_wait == '0);
        w_load = (r_wait == WW'(RD_LAT));
        if (r_wait == WW'(RD_LAT + 1)) w_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        bias_weights_bram_ena   = 1'b1;
        bias_weights_bram_addra = w_waddr;
        result_bram_ena         = 1'b1;
        result_bram_addra       = w_daddr;
        w_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        bias_weights_bram_addra = w_waddr;
        result_bram_addra       = w_daddr;
        // Operands are valid on the last wait cycle; accumulate there.
        w_en = (r_wait == WW'(RD_LAT - 1));
        if (w_en) w_nxt = S_MAC;
      end
      S_MAC: begin
        busy  = 1'b1;
        w_nxt = w_last_el ? S_WR : S_FETCH;
      end
      S_WR: begin
        busy = 1'b1;
        result_bram_ena   = 1'b1;
        result_bram_wea   = 1'b1;
        result_bram_addra = w_oaddr;
        result_bram_dina  = w_y;
        w_nxt = S_NXT;
      end
      S_NXT: begin
        busy  = 1'b1;
        w_nxt = w_last_px ? S_FIN : S_BIAS;
      end
      S_FIN: begin
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_f     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_ch    <= '0;
      r_ky    <= '0;
      r_kx    <= '0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == S_BIAS || r_state == S_WAIT)
          && w_nxt == r_state)
        r_wait <= r_wait + 1'b1;
      else
        r_wait <= '0;
      if (r_state == S_IDLE && start) begin
        r_f  <= '0;
        r_r  <= '0;
        r_c  <= '0;
        r_ch <= '0;
        r_ky <= '0;
        r_kx <= '0;
      end
      if (r_state == S_MAC) begin
        if (r_kx == KW'(K_SIZE - 1)) begin
          r_kx <= '0;
          if (r_ky == KW'(K_SIZE - 1)) begin
            r_ky <= '0;
            r_ch <= (r_ch == CW'(IN_CH - 1)) ? '0 : r_ch + 1'b1;
          end else begin
            r_ky <= r_ky + 1'b1;
          end
        end else begin
          r_kx <= r_kx + 1'b1;
        end
      end
      if (r_state == S_NXT) begin
        if (r_c == OW'(OUT_SIZE - 1)) begin
          r_c <= '0;
          if (r_r == OW'(OUT_SIZE - 1)) begin
            r_r <= '0;
            r_f <= (r_f == FW'(OUT_CH - 1)) ? '0 : r_f + 1'b1;
          end else begin
            r_r <= r_r + 1'b1;
          end
        end else begin
          r_c <= r_c + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_param.sv
// Bench for conv_layer_param: four small configurations sharing one
// BRAM image, with a write scoreboard per scenario.
module tb_conv_layer_param;
  import lenet_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st[4];
  logic        busy_w[4], done_w[4];
  logic        bw_ena[4], rs_ena[4], rs_wea[4];
  logic [15:0] bw_addr[4], bw_dout[4];
  logic [12:0] rs_addr[4];
  logic [15:0] rs_din[4], rs_dout[4];

  logic [15:0] wmem[64];
  logic [15:0] dmem[64];
  logic [15:0] bmem[4];
  logic [15:0] bwp[4][3];
  logic [15:0] rdp[4][3];

  logic [30:0] exp_q[$];
  logic [30:0] got_q[$];
  int          done_cnt[4];
  int          tests = 0;
  int          fails = 0;

  // d0: 4x4 in, 2 filters, RD_LAT 2, no ReLU
  // d1: 3x3 in (1x1 out), ReLU on
  // d2/d3: 4x4 in, RD_LAT 1 / 3
  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int INS = (g == 1) ? 3 : 4;
    localparam int OCH = (g == 0) ? 2 : 1;
    localparam int RDL = (g == 2) ? 1 : ((g == 3) ? 3 : 2);
    localparam int RLU = (g == 1) ? 1 : 0;
    conv_layer_param #(
      .IN_CH(1), .OUT_CH(OCH), .IN_SIZE(INS), .K_SIZE(3),
      .STRIDE(1), .RD_LAT(RDL), .RELU_EN(RLU)
    ) u_dut (
      .clk                    (clk),
      .rst                    (rst),
      .start                  (st[g]),
      .busy                   (busy_w[g]),
      .done                   (done_w[g]),
      .bias_weights_bram_ena  (bw_ena[g]),
      .bias_weights_bram_addra(bw_addr[g]),
      .bias_weights_bram_douta(bw_dout[g]),
      .result_bram_ena        (rs_ena[g]),
      .result_bram_wea        (rs_wea[g]),
      .result_bram_addra      (rs_addr[g]),
      .result_bram_dina       (rs_din[g]),
      .result_bram_douta      (rs_dout[g])
    );
    assign bw_dout[g] = bwp[g][RDL-1];
    assign rs_dout[g] = rdp[g][RDL-1];
  end

  function automatic logic [15:0] bw_rd(input logic [15:0] a);
    int i;
    i = int'(a) - MM_B_BASE;
    if (i >= 0 && i < 4) return bmem[i];
    i = int'(a) - MM_W_BASE;
    if (i >= 0 && i < 64) return wmem[i];
    return 16'hDEAD;
  endfunction

  function automatic logic [15:0] d_rd(input logic [12:0] a);
    int i;
    i = int'(a) - MM_IN_BASE;
    if (i >= 0 && i < 64) return dmem[i];
    return 16'hBEEF;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      for (int k = 2; k > 0; k--) begin
        bwp[g][k] <= bwp[g][k-1];
        rdp[g][k] <= rdp[g][k-1];
      end
      if (bw_ena[g]) bwp[g][0] <= bw_rd(bw_addr[g]);
      if (rs_ena[g] && !rs_wea[g]) rdp[g][0] <= d_rd(rs_addr[g]);
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rs_ena[g] && rs_wea[g])
        got_q.push_back({2'(g), rs_addr[g], rs_din[g]});
      if (done_w[g]) done_cnt[g] <= done_cnt[g] + 1;
    end
  end

  task automatic fill(input logic [15:0] d, input bit idx,
                      input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < 64; i++) begin
      dmem[i] = idx ? 16'(i << 8) : d;
      wmem[i] = (i < 9) ? w0 : w1;
    end
    bmem[0] = b0;
    bmem[1] = b1;
    bmem[2] = 16'h0;
    bmem[3] = 16'h0;
  endtask

  task automatic push(input int g, input int off, input logic [15:0] v);
    exp_q.push_back({2'(g), 13'(MM_OUT_BASE + off), v});
  endtask

  // Pulse start; cyc = cycles from start acceptance to done (-1 on timeout).
  task automatic launch(input int g, input int extra, output int cyc);
    @(negedge clk); st[g] = 1'b1;
    @(negedge clk); st[g] = 1'b0;
    cyc = 1;
    while (!done_w[g] && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      st[g] = (cyc == extra);
    end
    if (!done_w[g]) cyc = -1;
    @(negedge clk); st[g] = 1'b0;
  endtask

  function automatic logic any_out(input int g);
    return busy_w[g] | done_w[g] | bw_ena[g] | rs_ena[g] | rs_wea[g]
      | (|bw_addr[g]) | (|rs_addr[g]) | (|rs_din[g]);
  endfunction

  task automatic test_reset;
    logic a;
    @(negedge clk);
    a = 1'b0;
    for (int g = 0; g < 4; g++) a |= any_out(g);
    tests++;
    if (a !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0", a);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL reset_nowrite: got %0d writes want 0", got_q.size());
    end
  endtask

  task automatic test_unit_fc;
    int cyc, dc;
    logic [30:0] e, a;
    fill(16'h0100, 0, 16'h0100, 16'h0100, 16'h0, 16'h0);
    push(1, 0, 16'h0900);
    dc = done_cnt[1];
    launch(1, 0, cyc);
    tests++;
    if (cyc !== 43) begin
      fails++; $display("FAIL fc_cycles: got %0d want 43", cyc);
    end
    tests++;
    if (done_cnt[1] !== dc + 1) begin
      fails++; $display("FAIL fc_done: got %0d want %0d", done_cnt[1] - dc, 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++; $display("FAIL fc_write: got %h want %h", a, e);
      end
    end
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL fc_extra: got %0d want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_relu;
    int cyc;
    logic [30:0] e, a;
    fill(16'h0100, 0, 16'hFF00, 16'hFF00, 16'h0, 16'h0);
    push(1, 0, 16'h0000);
    launch(1, 0, cyc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++; $display("FAIL relu_write: got %h want %h", a, e);
      end
    end
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL relu_extra: got %0d want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic push_index_d0;
    push(0, 0, 16'h2D00); push(0, 1, 16'h3600);
    push(0, 2, 16'h5100); push(0, 3, 16'h5A00);
    push(0, 4, 16'h5B00); push(0, 5, 16'h6D00);
    push(0, 6, 16'h7FFF); push(0, 7, 16'h7FFF);
  endtask

  task automatic test_index;
    int cyc, dc;
    logic [30:0] e, a;
    fill(16'h0, 1, 16'h0100, 16'h0200, 16'h0, 16'h0100);
    push_index_d0();
    dc = done_cnt[0];
    launch(0, 0, cyc);
    tests++;
    if (cyc !== 337) begin
      fails++; $display("FAIL index_cycles: got %0d want 337", cyc);
    end
    tests++;
    if (done_cnt[0] !== dc + 1) begin
      fails++; $display("FAIL index_done: got %0d want 1", done_cnt[0] - dc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++; $display("FAIL index_write: got %h want %h", a, e);
      end
    end
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL index_extra: got %0d want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_neg_sat;
    int cyc;
    logic [30:0] e, a;
    fill(16'h0100, 0, 16'hFF00, 16'hFF00, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) push(0, i, 16'hF700);
    launch(0, 0, cyc);
    fill(16'h7FFF, 0, 16'h7FFF, 16'h8001, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) push(0, i, (i < 4) ? 16'h7FFF : 16'h8000);
    launch(0, 0, cyc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++; $display("FAIL negsat_write: got %h want %h", a, e);
      end
    end
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL negsat_extra: got %0d want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int cyc, dc;
    logic [30:0] e, a;
    fill(16'h0, 1, 16'h0100, 16'h0200, 16'h0, 16'h0100);
    dc = done_cnt[0];
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (any_out(0) !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got %b want 0", any_out(0));
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    tests++;
    if (got_q.size() !== 0 || done_cnt[0] !== dc) begin
      fails++;
      $display("FAIL midrst_quiet: got writes=%0d dones=%0d want 0 0",
               got_q.size(), done_cnt[0] - dc);
      got_q.delete();
    end
    push_index_d0();
    launch(0, 0, cyc);
    tests++;
    if (cyc !== 337) begin
      fails++; $display("FAIL midrst_cycles: got %0d want 337", cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++; $display("FAIL midrst_write: got %h want %h", a, e);
      end
    end
    tests++;
    if (got_q.size() !== 0) begin
      fails++; $display("FAIL midrst_extra: got %0d want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_rd_lat;
    int cyc, dc;
    int want[2] = '{129, 209};
    logic [30:0] e, a;
    fill(16'h0, 1, 16'h0100, 16'h0100, 16'h0, 16'h0);
    for (int j = 0; j < 2; j++) begin
      push(2 + j, 0, 16'h2D00); push(2 + j, 1, 16'h3600);
      push(2 + j, 2, 16'h5100); push(2 + j, 3, 16'h5A00);
      dc = done_cnt[2 + j];
      // d3 also sees a second start pulse while busy
      launch(2 + j, (j == 1) ? 30 : 0, cyc);
      tests++;
      if (cyc !== want[j]) begin
        fails++; $display("FAIL rdlat_cycles d%0d: got %0d want %0d", 2 + j, cyc, want[j]);
      end
      repeat (20) @(negedge clk);
      tests++;
      if (busy_w[2 + j] !== 1'b0 || done_cnt[2 + j] !== dc + 1) begin
        fails++;
        $display("FAIL rdlat_idle d%0d: got busy=%b dones=%0d want 0 1",
                 2 + j, busy_w[2 + j], done_cnt[2 + j] - dc);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        tests++;
        if (a !== e) begin
          fails++; $display("FAIL rdlat_write d%0d: got %h want %h", 2 + j, a, e);
        end
      end
      tests++;
      if (got_q.size() !== 0) begin
        fails++; $display("FAIL rdlat_extra d%0d: got %0d want 0", 2 + j, got_q.size());
        got_q.delete();
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      st[g] = 1'b0;
      done_cnt[g] = 0;
    end
    test_reset();
    test_unit_fc();
    test_relu();
    test_index();
    test_neg_sat();
    test_reset_mid();
    test_rd_lat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
